// File: rtl/adc_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : adc_scan_pkg                                               |
// | Description : Shared types and constants for the ADC clock-phase scan    |
// |               sequencer: FSM state encoding, result codes, bus widths    |
// |               and the strobe-averaging depth.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package adc_scan_pkg;

  localparam int DLY_W = 6;   // scan_delay / best_delay width
  localparam int CNT_W = 7;   // count2 width
  localparam int MET_W = 9;   // accumulator / best_metric width
  localparam int AVG_N = 4;   // strobes per step when averaging is built in

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_STRB = 3'd3,
    ST_EVAL      = 3'd4,
    ST_APPLY     = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_SAT     = 2'd2,
    ERR_RANGE   = 2'd3
  } err_t;

  // Width of a down-counter that must hold (max(a,b) - 1).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : scan_sequencer_if                                          |
// | Description : Control/result bundle between a scan controller and the    |
// |               scan_sequencer.                                            |
// |   master : drives start, abort, scan_min, scan_max, monitor_strb,        |
// |            count2, saturated; receives the results.                      |
// |   slave  : the sequencer side; drives scan_delay, delay_trig, busy,      |
// |            done, error, best_delay, best_metric.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface scan_sequencer_if;
  import adc_scan_pkg::*;

  logic             start;
  logic             abort;
  logic [DLY_W-1:0] scan_min;
  logic [DLY_W-1:0] scan_max;
  logic             monitor_strb;
  logic [CNT_W-1:0] count2;
  logic             saturated;
  logic [DLY_W-1:0] scan_delay;
  logic             delay_trig;
  logic             busy;
  logic             done;
  logic [1:0]       error;
  logic [DLY_W-1:0] best_delay;
  logic [MET_W-1:0] best_metric;

  modport master (
    output start, abort, scan_min, scan_max, monitor_strb, count2, saturated,
    input  scan_delay, delay_trig, busy, done, error, best_delay, best_metric
  );

  modport slave (
    input  start, abort, scan_min, scan_max, monitor_strb, count2, saturated,
    output scan_delay, delay_trig, busy, done, error, best_delay, best_metric
  );

endinterface
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cycle_timer                                                |
// | Description : Loadable down-counter that stops at zero and flags it.     |
// |   clk40     in  clock                                                    |
// |   rst       in  synchronous active-low reset (count -> 0)                |
// |   load_i    in  load value_i on this edge                                |
// |   value_i   in  load value (terminal flag rises value_i+1 cycles later   |
// |                 counting the load cycle's successor as the first)        |
// |   expired_o out count is zero                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk40,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] value_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk40) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_sequencer                                             |
// | Description : Sweeps the ADC clock phase from scan_min to scan_max,      |
// |               collects the alignment-monitor metric at each phase and    |
// |               applies the phase with the highest metric.                 |
// |   clk40 in  sole clock                                                   |
// |   rst   in  synchronous active-low reset                                 |
// |   bus   slave modport of scan_sequencer_if (start/abort/range/monitor    |
// |         inputs; scan_delay, delay_trig, busy, done, error, best_* out)   |
// | Build option: define SCAN_SEQ_AVG_EN to sum AVG_N monitor strobes per    |
// |               step instead of one.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module scan_sequencer import adc_scan_pkg::*; #(
  parameter int SETTLE_CYC  = 80,
  parameter int TIMEOUT_CYC = 4096
) (
  input  wire logic       clk40,
  input  wire logic       rst,
  scan_sequencer_if.slave bus
);

  localparam int               TMR_W      = timer_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state_q;
  logic [DLY_W-1:0] cur_q;
  logic [DLY_W-1:0] max_q;
  logic [MET_W-1:0] acc_q;
  logic [DLY_W-1:0] scan_delay_q;
  logic             delay_trig_q;
  logic             busy_q;
  logic             done_q;
  err_t             error_q;
  logic [DLY_W-1:0] best_delay_q;
  logic [MET_W-1:0] best_metric_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expired;
  logic             strb_last;
  logic             strb_reload;
  logic             better;
  logic [DLY_W-1:0] eval_best_delay;
  logic [MET_W-1:0] strb_metric;

  assign strb_metric     = {{(MET_W-CNT_W){1'b0}}, bus.count2};
  assign better          = (acc_q > best_metric_q);  // strict: ties keep lower delay
  assign eval_best_delay = better ? cur_q : best_delay_q;

`ifdef SCAN_SEQ_AVG_EN
  localparam int AVG_W = $clog2(AVG_N);
  logic [AVG_W-1:0] strb_cnt_q;

  always_ff @(posedge clk40) begin
    if (!rst) begin
      strb_cnt_q <= '0;
    end else if (state_q == ST_TRIG) begin
      strb_cnt_q <= '0;
    end else if ((state_q == ST_WAIT_STRB) && bus.monitor_strb) begin
      strb_cnt_q <= strb_cnt_q + AVG_W'(1);
    end
  end

  assign strb_last   = (strb_cnt_q == AVG_W'(AVG_N - 1));
  // Each strobe gives the monitor a fresh timeout window for the next one.
  assign strb_reload = (state_q == ST_WAIT_STRB) && bus.monitor_strb;
`else
  assign strb_last   = 1'b1;
  assign strb_reload = 1'b0;
`endif

  // One timer covers both phases: loaded leaving TRIG for the settle time,
  // reloaded on the last SETTLE cycle for the strobe timeout.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = SETTLE_LD;
    if (state_q == ST_TRIG) begin
      tmr_load = 1'b1;
    end else if (((state_q == ST_SETTLE) && tmr_expired) || strb_reload) begin
      tmr_load  = 1'b1;
      tmr_value = TIMEOUT_LD;
    end
  end

  cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk40     (clk40),
    .rst       (rst),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk40) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      max_q         <= '0;
      acc_q         <= '0;
      scan_delay_q  <= '0;
      delay_trig_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= ERR_OK;
      best_delay_q  <= '0;
      best_metric_q <= '0;
    end else begin
      delay_trig_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.scan_min > bus.scan_max) begin
              error_q <= ERR_RANGE;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              cur_q         <= bus.scan_min;
              max_q         <= bus.scan_max;
              acc_q         <= '0;
              best_metric_q <= '0;
              best_delay_q  <= bus.scan_min;
              error_q       <= ERR_OK;
              scan_delay_q  <= bus.scan_min;
              delay_trig_q  <= 1'b1;
              state_q       <= ST_TRIG;
            end
          end
        end

        ST_TRIG: begin
          // Jumping straight to APPLY would put two trig pulses back to back,
          // so an abort seen here is parked in error_q and acted on in the
          // first SETTLE cycle.
          if (bus.abort) begin
            error_q <= ERR_RANGE;
          end
          state_q <= ST_SETTLE;
        end

        ST_SETTLE: begin
          // monitor_strb is deliberately ignored while the delay settles.
          if (bus.abort || (error_q == ERR_RANGE)) begin
            error_q      <= ERR_RANGE;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end else if (bus.saturated) begin
            error_q      <= ERR_SAT;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end else if (tmr_expired) begin
            state_q <= ST_WAIT_STRB;
          end
        end

        ST_WAIT_STRB: begin
          if (bus.abort) begin
            error_q      <= ERR_RANGE;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end else if (bus.saturated) begin
            error_q      <= ERR_SAT;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end else if (bus.monitor_strb) begin
            acc_q <= acc_q + strb_metric;
            if (strb_last) begin
              state_q <= ST_EVAL;
            end
          end else if (tmr_expired) begin
            error_q      <= ERR_TIMEOUT;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end
        end

        ST_EVAL: begin
          if (bus.abort) begin
            error_q      <= ERR_RANGE;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end else if (bus.saturated) begin
            error_q      <= ERR_SAT;
            scan_delay_q <= best_delay_q;
            delay_trig_q <= 1'b1;
            state_q      <= ST_APPLY;
          end else begin
            if (better) begin
              best_metric_q <= acc_q;
              best_delay_q  <= cur_q;
            end
            // Compare before incrementing so scan_max = 63 never wraps cur.
            if (cur_q == max_q) begin
              scan_delay_q <= eval_best_delay;
              delay_trig_q <= 1'b1;
              state_q      <= ST_APPLY;
            end else begin
              cur_q        <= cur_q + DLY_W'(1);
              acc_q        <= '0;
              scan_delay_q <= cur_q + DLY_W'(1);
              delay_trig_q <= 1'b1;
              state_q      <= ST_TRIG;
            end
          end
        end

        ST_APPLY: begin
          done_q  <= 1'b1;
          state_q <= ST_FINISH;
        end

        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.scan_delay  = scan_delay_q;
  assign bus.delay_trig  = delay_trig_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.best_delay  = best_delay_q;
  assign bus.best_metric = best_metric_q;

endmodule
`default_nettype wire
